// File: rtl/gate_ops_pkg.sv
// gate_ops_pkg
//   Shared definitions for the gate operation scheduler and its gate unit:
//   opcode width, opcode enumeration and scheduler FSM state enumeration.
package gate_ops_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_NAND = 3'd2,
      OP_NOR  = 3'd3,
      OP_XOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_NOT  = 3'd6,
      OP_RSVD = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/gate_alu.sv
// gate_alu
//   Purely combinational basic-gate unit, shared by the scheduler.
//   Ports:
//     op   in  OP_W   opcode (see op_e)
//     a    in  WIDTH  operand A
//     b    in  WIDTH  operand B (unused for NOT)
//     y    out WIDTH  result; zero for the reserved opcode
//     err  out 1      high for the reserved opcode
module gate_alu
   import gate_ops_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic             err
);

   always_comb begin
      y   = '0;
      err = 1'b0;
      case (op_e'(op))
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_XOR:  y = a ^ b;
         OP_XNOR: y = ~(a ^ b);
         OP_NOT:  y = ~a;
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/gate_op_scheduler.sv
// gate_op_scheduler
//   Round-robin scheduler sharing one gate_alu between N_REQ requesters.
//   A granted request is captured, executed for one cycle and returned as a
//   registered, tagged response held until the consumer accepts it.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     req_valid/req_ready   per-requester handshake (at most one ready high)
//     req_op/req_a/req_b    packed per-requester opcode and operands
//     rsp_valid/rsp_ready   response handshake
//     rsp_id/rsp_data/rsp_err  owner index, result, reserved-opcode flag
module gate_op_scheduler
   import gate_ops_pkg::*;
#(
   parameter  int N_REQ = 4,
   parameter  int WIDTH = 8,
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [OP_W*N_REQ-1:0]   req_op,
   input  logic [WIDTH*N_REQ-1:0]  req_a,
   input  logic [WIDTH*N_REQ-1:0]  req_b,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [WIDTH-1:0]        rsp_data,
   output logic                    rsp_err
);

   state_e            state_q, state_d;
   logic [ID_W-1:0]   last_grant_q, last_grant_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;

   logic              win_found;
   logic [ID_W-1:0]   win_idx;
   logic              accept;
   logic [WIDTH-1:0]  alu_y;
   logic              alu_err;

   // Round-robin search starting just after the last granted requester.
   always_comb begin
      int idx;
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = int'(last_grant_q) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!win_found && req_valid[idx]) begin
            win_found = 1'b1;
            win_idx   = ID_W'(idx);
         end
      end
   end

   assign accept = (state_q == ST_IDLE) && win_found;

   // Ready is gated by rst_n so it is forced low while reset is asserted,
   // even though it is otherwise combinational from req_valid.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = rst_n && accept && (win_idx == ID_W'(gi));
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (win_found) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      rsp_valid = (state_q == ST_RESP);
   end

   gate_alu #(.WIDTH(WIDTH)) u_alu (
      .op  (op_q),
      .a   (a_q),
      .b   (b_q),
      .y   (alu_y),
      .err (alu_err)
   );

   // Capture on accept, register the result in EXEC; response registers
   // otherwise hold, which keeps the outputs stable under backpressure.
   always_comb begin
      last_grant_d = last_grant_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      id_d         = id_q;
      rsp_id_d     = rsp_id_q;
      rsp_data_d   = rsp_data_q;
      rsp_err_d    = rsp_err_q;
      if (accept) begin
         last_grant_d = win_idx;
         id_d         = win_idx;
         op_d         = req_op[int'(win_idx)*OP_W +: OP_W];
         a_d          = req_a[int'(win_idx)*WIDTH +: WIDTH];
         b_d          = req_b[int'(win_idx)*WIDTH +: WIDTH];
      end
      if (state_q == ST_EXEC) begin
         rsp_id_d   = id_q;
         rsp_data_d = alu_y;
         rsp_err_d  = alu_err;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= ID_W'(N_REQ - 1);
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         id_q         <= '0;
         rsp_id_q     <= '0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         id_q         <= id_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign rsp_id   = rsp_id_q;
   assign rsp_data = rsp_data_q;
   assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_gate_op_scheduler.sv
// tb_gate_op_scheduler
//   Directed and randomized checks of gate_op_scheduler (N_REQ=4, WIDTH=8)
//   against a transaction-level model: one owed response at a time, due two
//   cycles after its accept, and round-robin winner selection.
module tb_gate_op_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [11:0] req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_data;
   logic        rsp_err;

   always #5 clk = ~clk;

   gate_op_scheduler #(.N_REQ(4), .WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Model state
   int       cyc = 0;
   int       m_last = 3;
   bit       m_pend = 0;
   int       m_rsp_at = 0;
   int       m_id;
   logic [7:0] m_data;
   logic     m_err;

   // Observations from the most recent tick
   int       acc = -1;
   int       dut_g = -1;
   int       dut_cnt = 0;
   int       acc_cyc = 0;
   int       hs_cyc = 0;
   bit       hs_seen = 0;
   logic [7:0] hs_data;
   logic [1:0] hs_id;
   logic     hs_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [7:0] gate_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return ~(a & b);
         3'd3: return ~(a | b);
         3'd4: return a ^ b;
         3'd5: return ~(a ^ b);
         3'd6: return ~a;
         default: return 8'h00;
      endcase
   endfunction

   task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      req_valid[i]      = 1'b1;
      req_op[3*i +: 3]  = op;
      req_a[8*i +: 8]   = a;
      req_b[8*i +: 8]   = b;
   endtask

   task automatic rand_req(input int i);
      set_req(i, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
   endtask

   // One clock cycle: called at a negedge with inputs already driven.
   task automatic tick();
      logic [3:0] er;
      bit         erv;
      int         w;
      logic [2:0] op;
      #1;
      w = -1;
      if (rst_n && !m_pend) begin
         for (int k = 1; k <= 4; k++) begin
            int i;
            i = (m_last + k) % 4;
            if (w < 0 && req_valid[i]) w = i;
         end
      end
      er  = (w >= 0) ? 4'(1 << w) : 4'b0000;
      erv = rst_n && m_pend && (cyc >= m_rsp_at);
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("rsp_valid", 32'(rsp_valid), 32'(erv));
      if (erv) begin
         chk("rsp_id",   32'(rsp_id),   32'(m_id));
         chk("rsp_data", 32'(rsp_data), 32'(m_data));
         chk("rsp_err",  32'(rsp_err),  32'(m_err));
      end
      dut_g = -1;
      dut_cnt = $countones(req_ready);
      for (int i = 0; i < 4; i++) if (req_ready[i]) dut_g = i;
      acc = w;
      if (w >= 0) begin
         op       = req_op[3*w +: 3];
         m_pend   = 1;
         m_rsp_at = cyc + 2;
         m_id     = w;
         m_data   = gate_ref(op, req_a[8*w +: 8], req_b[8*w +: 8]);
         m_err    = (op == 3'd7);
         m_last   = w;
         acc_cyc  = cyc;
      end
      if (erv && rsp_ready) begin
         m_pend  = 0;
         hs_seen = 1;
         hs_cyc  = cyc;
         hs_data = rsp_data;
         hs_id   = rsp_id;
         hs_err  = rsp_err;
      end
      cyc++;
      @(negedge clk);
   endtask

   // Reset asserted mid-cycle; outputs must clear without a clock edge.
   task automatic apply_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_id",    32'(rsp_id),    32'd0);
      chk("rst_rsp_data",  32'(rsp_data),  32'd0);
      chk("rst_rsp_err",   32'(rsp_err),   32'd0);
      m_pend = 0;
      m_last = 3;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_acc(input string tag, input int want);
      for (int t = 0; t < 20 && acc != want; t++) tick();
      chk(tag, 32'(acc), 32'(want));
   endtask

   logic [7:0] sweep_exp [0:7];
   logic [7:0] snap;

   initial begin
      sweep_exp[0] = 8'h00; sweep_exp[1] = 8'hFF; sweep_exp[2] = 8'hFF; sweep_exp[3] = 8'h00;
      sweep_exp[4] = 8'hFF; sweep_exp[5] = 8'h00; sweep_exp[6] = 8'h3A; sweep_exp[7] = 8'h00;
      rst_n = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
      @(negedge clk);
      apply_reset();
      for (int i = 0; i < 10; i++) tick();

      // Opcode sweep from requester 1, then reserved op, then a normal op.
      rsp_ready = 1'b1;
      for (int s = 0; s < 9; s++) begin
         int op;
         op = (s == 8) ? 0 : s;
         set_req(1, 3'(op), 8'hC5, 8'h3A);
         acc = -1;
         wait_acc("sweep_accept", 1);
         req_valid[1] = 1'b0;
         hs_seen = 0;
         for (int t = 0; t < 10 && !hs_seen; t++) tick();
         chk("sweep_seen",    32'(hs_seen), 32'd1);
         chk("sweep_latency", 32'(hs_cyc - acc_cyc), 32'd2);
         chk("sweep_id",      32'(hs_id), 32'd1);
         chk("sweep_data",    32'(hs_data), 32'(sweep_exp[op]));
         chk("sweep_err",     32'(hs_err), (op == 7) ? 32'd1 : 32'd0);
      end

      // Fairness: all requesters valid from reset.
      req_valid = '0;
      apply_reset();
      for (int i = 0; i < 4; i++) rand_req(i);
      for (int n = 0; n < 8; n++) begin
         acc = -1;
         for (int t = 0; t < 20 && acc < 0; t++) tick();
         chk("fair_order",  32'(dut_g), 32'(n % 4));
         chk("fair_onehot", 32'(dut_cnt), 32'd1);
         if (acc >= 0) rand_req(acc);
      end
      req_valid = '0;
      for (int t = 0; t < 4; t++) tick();

      // Backpressure: last grant is 3, so requester 2 wins next.
      rsp_ready = 1'b0;
      set_req(2, 3'd4, 8'h96, 8'h5A);
      acc = -1;
      wait_acc("bp_accept", 2);
      req_valid[2] = 1'b0;
      set_req(0, 3'd1, 8'h11, 8'h22);
      set_req(3, 3'd2, 8'h0F, 8'hF3);
      tick();
      tick();
      snap = rsp_data;
      chk("bp_first_data", 32'(snap), 32'h00CC);
      for (int t = 0; t < 5; t++) begin
         #1;
         chk("bp_valid_hold", 32'(rsp_valid), 32'd1);
         chk("bp_data_hold",  32'(rsp_data), 32'(snap));
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      tick();
      chk("bp_next_grant", 32'(dut_g), 32'd3);
      req_valid[3] = 1'b0;

      // Reset while the response is pending.
      tick();
      tick();
      #1;
      chk("mid_rsp_valid", 32'(rsp_valid), 32'd1);
      apply_reset();
      for (int i = 0; i < 4; i++) rand_req(i);
      tick();
      chk("post_rst_grant", 32'(dut_g), 32'd0);
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int t = 0; t < 4; t++) tick();

      // Randomized traffic with random backpressure.
      for (int t = 0; t < 400; t++) begin
         for (int i = 0; i < 4; i++)
            if (!req_valid[i] && $urandom_range(0, 2) == 0) rand_req(i);
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
         if (acc >= 0) req_valid[acc] = 1'b0;
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int t = 0; t < 5; t++) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
